// File: rtl/dvi_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module      : dvi_frame_sequencer
// Description : Per-frame reset/start sequencer for the DVI stimulus engine,
//               with line/pixel tracking and solid or colour-bar pixel words.
//               Optional colour bars: define DVI_SEQ_BARS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dvi_frame_sequencer #(
   parameter int GAP_CYCLES = 64,
   parameter int MAX_LINES  = 720
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [23:0] solid_color,
   input  logic        pattern_sel,
   output logic        eng_reset,
   output logic        eng_start,
   input  logic        eng_hsync,
   input  logic        eng_vsync,
   output logic [23:0] color,
   output logic        busy,
   output logic        frame_done,
   output logic [9:0]  line,
   output logic [15:0] frame_count,
   output logic        line_err
);

   localparam logic [15:0] c_GAP_LOAD  = 16'(GAP_CYCLES - 1);
   localparam logic [9:0]  c_MAX_LINES = 10'(MAX_LINES);
   localparam logic [9:0]  c_LINE_SAT  = 10'd1023;
   localparam logic [10:0] c_COL_SAT   = 11'd2047;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERST  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        w_eng_reset;
   logic        w_eng_start;

   logic        r_hs_prev;
   logic        r_vs_prev;
   logic        w_hs_rise;
   logic        w_vs_rise;

   logic [15:0] r_gap_cnt;
   logic [9:0]  r_line;
   logic [10:0] r_col;
   logic [15:0] r_frame_count;
   logic        r_line_err;
   logic        r_frame_done;

   assign w_hs_rise = eng_hsync & ~r_hs_prev;
   assign w_vs_rise = eng_vsync & ~r_vs_prev;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_eng_reset  = 1'b0;
      w_eng_start  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_eng_reset = 1'b1;
            if (enable) begin
               w_state_next = S_ERST;
            end
         end
         S_ERST: begin
            w_eng_reset  = 1'b1;
            w_state_next = S_START;
         end
         S_START: begin
            w_eng_start  = 1'b1;
            w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_vs_rise) begin
               w_state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 16'd0) begin
               w_state_next = enable ? S_ERST : S_IDLE;
            end
         end
         default: begin
            w_eng_reset  = 1'b1;
            w_state_next = S_IDLE;
         end
      endcase
   end

   // The engine sees reset in the same cycle the sequencer does.
   assign eng_reset = w_eng_reset | reset;
   assign eng_start = w_eng_start;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hs_prev     <= 1'b0;
         r_vs_prev     <= 1'b0;
         r_gap_cnt     <= 16'd0;
         r_line        <= 10'd0;
         r_col         <= 11'd0;
         r_frame_count <= 16'd0;
         r_line_err    <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_hs_prev    <= eng_hsync;
         r_vs_prev    <= eng_vsync;
         r_frame_done <= 1'b0;

         if ((r_state == S_ERST) || eng_hsync) begin
            r_col <= 11'd0;
         end else if ((r_state == S_RUN) && (r_col != c_COL_SAT)) begin
            r_col <= r_col + 11'd1;
         end

         case (r_state)
            S_ERST: begin
               r_line <= 10'd0;
            end
            S_RUN: begin
               // A vsync edge ends the frame and masks a coincident hsync edge.
               if (w_vs_rise) begin
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
                  r_gap_cnt     <= c_GAP_LOAD;
                  if (r_line != c_MAX_LINES) begin
                     r_line_err <= 1'b1;
                  end
               end else if (w_hs_rise && (r_line != c_LINE_SAT)) begin
                  r_line <= r_line + 10'd1;
               end
            end
            S_GAP: begin
               if (r_gap_cnt != 16'd0) begin
                  r_gap_cnt <= r_gap_cnt - 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign line        = r_line;
   assign frame_count = r_frame_count;
   assign line_err    = r_line_err;
   assign frame_done  = r_frame_done;

`ifdef DVI_SEQ_BARS_EN
   logic        r_mode;
   logic [23:0] w_bar_color;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mode <= 1'b0;
      end else if (r_state == S_START) begin
         r_mode <= pattern_sel;
      end
   end

   // Eight 256-pixel-wide bars across the line.
   always_comb begin
      w_bar_color = 24'h000000;
      case (r_col[10:8])
         3'd0:    w_bar_color = 24'hFFFFFF;
         3'd1:    w_bar_color = 24'hFFFF00;
         3'd2:    w_bar_color = 24'h00FFFF;
         3'd3:    w_bar_color = 24'h00FF00;
         3'd4:    w_bar_color = 24'hFF00FF;
         3'd5:    w_bar_color = 24'hFF0000;
         3'd6:    w_bar_color = 24'h0000FF;
         default: w_bar_color = 24'h000000;
      endcase
   end

   assign color = r_mode ? w_bar_color : solid_color;
`else
   logic w_pattern_sel_unused;

   assign w_pattern_sel_unused = pattern_sel;
   assign color                = solid_color;
`endif

endmodule

`default_nettype wire

// File: doc/dvi_frame_sequencer.md
# dvi_frame_sequencer

Frame-level controller for the DVI stimulus engine in the HDMI output core. It resets and starts the engine once per frame, tracks line and pixel position from the engine's hsync/vsync outputs, and supplies the per-pixel `color` word. After a programmable blanking gap it re-arms the engine, so a single `enable` produces continuous back-to-back 1280x720 frames.

## Interface
Parameters:
- `GAP_CYCLES`, default 64: idle cycles between the engine's vsync and the next engine reset; legal range 1..65535.
- `MAX_LINES`, default 720: line count expected per frame; used only for the `line_err` flag.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; while high, frames run back-to-back.
- `solid_color`  in  24  RGB 8:8:8 value used in solid mode.
- `pattern_sel`  in  1  0 = solid colour, 1 = colour bars; sampled only in START.
- `eng_reset`  out  1  reset to the engine.
- `eng_start`  out  1  start to the engine.
- `eng_hsync`  in  1  engine hsync (registered in the engine).
- `eng_vsync`  in  1  engine vsync (registered in the engine).
- `color`  out  24  pixel word to the engine; combinational from internal registers.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `line`  out  10  lines begun in the current frame.
- `frame_count`  out  16  completed frames; wraps at 65535 -> 0.
- `line_err`  out  1  sticky; set when a frame ends with `line != MAX_LINES`.

## Operation
- FSM states: IDLE, ERST, START, RUN, GAP.
  - IDLE: `eng_reset` = 1. If `enable` = 1, go to ERST.
  - ERST: `eng_reset` = 1 for exactly 1 cycle; clear `line` and `col`. Go to START.
  - START: `eng_reset` = 0, `eng_start` = 1 for 1 cycle; latch `pattern_sel` into `mode`. Go to RUN.
  - RUN: a rising edge of `eng_hsync` (current = 1, previous = 0) increments `line`, saturating at 1023. A rising edge of `eng_vsync` pulses `frame_done`, increments `frame_count`, updates `line_err`, loads the gap counter with `GAP_CYCLES-1`, and goes to GAP.
  - GAP: `eng_reset` = 0. Decrement the gap counter. At 0: go to ERST if `enable` = 1, otherwise IDLE.
- `col` (11 bits):
  - cleared in every cycle where `eng_hsync` = 1;
  - increments in every RUN cycle where `eng_hsync` = 0;
  - saturates at 2047.
- `color`:
  - mode 0: `solid_color`.
  - mode 1: palette entry indexed by `col[10:8]`. Palette: 0 FFFFFF, 1 FFFF00, 2 00FFFF, 3 00FF00, 4 FF00FF, 5 FF0000, 6 0000FF, 7 000000.
- `enable` falling mid-frame does not abort: the current frame completes, then GAP runs, then IDLE.
- Simultaneous hsync and vsync rising edges in the same cycle: vsync wins; `line` is not incremented.

## Timing
- Reset values:
  - `eng_reset` = 1; `eng_start` = 0; `busy` = 0; `frame_done` = 0; `line` = 0; `frame_count` = 0; `line_err` = 0.
  - `col` = 0; `mode` = 0, so `color` = `solid_color`.
  - State = IDLE.
- `reset` asserted in any state returns every output to its reset value on the next edge. The engine receives `eng_reset` = 1 in the same cycle.
- `enable` high in IDLE at cycle n: ERST at n+1, START at n+2 (`eng_start` = 1), RUN from n+3.
- `frame_done` is high in the cycle after the vsync edge is seen, coincident with the first GAP cycle.
- Frame-to-frame latency from the vsync edge to the next ERST is `GAP_CYCLES`+1 cycles.
- Edge detection uses one register stage per sync input; no synchroniser is needed because both sync inputs are on the same clock.

## Configuration
- `DVI_SEQ_BARS_EN`:
  - Defined: colour-bar palette and `col[10:8]` indexing are compiled in; `pattern_sel` selects the mode.
  - Undefined: palette logic is removed, `mode` is tied to 0, `pattern_sel` is ignored, and `color` = `solid_color` always.
  - `col` tracking remains in both builds.

## Test plan
- Reset, then `enable` = 1 with an engine model -> `eng_reset` = 1 for exactly 1 cycle, `eng_start` pulse 2 cycles after `enable`; `busy` = 1 from the cycle after `enable`.
- Full frame, `pattern_sel` = 0, `solid_color` = 123456 -> every sampled pixel = 123456; `line` = 720 at vsync; `frame_done` pulses once; `frame_count` = 1; `line_err` = 0.
- `pattern_sel` = 1 (`DVI_SEQ_BARS_EN` defined) -> pixels at col 0..255 = FFFFFF, col 256..511 = FFFF00, col 1024..1279 = FF00FF, on every line.
- `GAP_CYCLES` = 4, `enable` held high -> vsync edge to next ERST = 5 cycles; 3 frames give `frame_count` = 3; `frame_count` preset near 65535 wraps to 0.
- `enable` dropped at line 300 -> frame completes to vsync, GAP runs, then IDLE with `eng_reset` = 1 and `busy` = 0.
- `reset` pulsed at line 400 -> next cycle: IDLE, `line` = 0, `frame_count` = 0, `eng_reset` = 1; an engine model ending at line 719 sets `line_err` = 1.
